// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (core and debug port)
// and the shared instruction/data memory.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();

   // core datapath port
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ready;

   // debug / program-loader port
   logic          dbg_req;
   logic          dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic [DW-1:0] dbg_rdata;
   logic          dbg_ready;
   logic          dbg_halt;

   // memory side
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   // current owner, one-hot: [0]=cpu, [1]=dbg
   logic [1:0]    grant;

   // arbiter side
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ready,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
      output dbg_rdata, dbg_ready,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output grant
   );

   // requester / memory side
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ready,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_halt,
      input  dbg_rdata, dbg_ready,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  grant
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the unified MIPS memory between the core
// datapath and the debug/program-loader port. Each granted transaction
// runs a fixed MEM_LAT-cycle access and ends with a one-cycle ready pulse
// to its owner. dbg_halt keeps the core from being granted new accesses.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 2
) (
   input  logic clk,
   input  logic reset,
   mem_port_arbiter_if.slave bus
);

   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // last_q doubles as the owner of the transaction in flight, because it
   // is loaded with the winner on every grant.
   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DBG = 1'b1
   } req_t;

   state_t        state_q,     state_d;
   logic [CW-1:0] cnt_q,       cnt_d;
   req_t          last_q,      last_d;
   logic [1:0]    grant_q,     grant_d;
   logic          mem_en_q,    mem_en_d;
   logic          mem_we_q,    mem_we_d;
   logic [AW-1:0] mem_addr_q,  mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

   logic cpu_elig;
   logic dbg_elig;
   logic pick_dbg;

   // Next-state and next-register values for the IDLE/ACCESS/DONE sequence.
   always_comb begin
      // NOTE: every signal written here gets its default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      grant_d     = grant_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;

      cpu_elig = bus.cpu_req && !bus.dbg_halt;
      dbg_elig = bus.dbg_req;
      // On a tie the requester that did not win last time goes next.
      pick_dbg = dbg_elig && (!cpu_elig || (last_q == REQ_CPU));

      unique case (state_q)
         IDLE: begin
            if (cpu_elig || dbg_elig) begin
               last_d   = pick_dbg ? REQ_DBG : REQ_CPU;
               grant_d  = pick_dbg ? 2'b10 : 2'b01;
               mem_en_d = 1'b1;
               if (pick_dbg) begin
                  mem_we_d    = bus.dbg_we;
                  mem_addr_d  = bus.dbg_addr;
                  mem_wdata_d = bus.dbg_wdata;
               end else begin
                  mem_we_d    = bus.cpu_we;
                  mem_addr_d  = bus.cpu_addr;
                  mem_wdata_d = bus.cpu_wdata;
               end
               cnt_d   = CW'(MEM_LAT - 1);
               state_d = ACCESS;
            end
         end

         ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               // Last access cycle: read data is valid now.
               if (!mem_we_q) begin
                  if (last_q == REQ_CPU) cpu_rdata_d = bus.mem_rdata;
                  else                   dbg_rdata_d = bus.mem_rdata;
               end
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               state_d  = DONE;
            end
         end

         DONE: begin
            // Address and data return to zero so the memory bus is quiet in IDLE.
            grant_d     = 2'b00;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            state_d     = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; async reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         last_q      <= REQ_DBG;
         grant_q     <= 2'b00;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         // NOTE: non-blocking assignments make every register sample the
         // pre-edge values, so ordering inside this block does not matter.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         grant_q     <= grant_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.dbg_rdata = dbg_rdata_q;

   // Ready is decoded from the registered DONE state and owner, so it is a
   // clean single-cycle pulse to exactly one requester.
   assign bus.cpu_ready = (state_q == DONE) && (last_q == REQ_CPU);
   assign bus.dbg_ready = (state_q == DONE) && (last_q == REQ_DBG);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected transactions
// into a scoreboard queue, a monitor checks the memory bus and the ready
// pulses against the queue front.
module tb_mem_port_arbiter;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int MEM_LAT = 2;

   typedef struct {
      bit          port;   // 0=cpu, 1=dbg
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;  // owner's rdata register at ready
   } exp_t;

   logic clk;
   logic reset;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   logic [31:0] mem [logic [31:0]];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Memory model: combinational read, write at the clock edge.
   always @(bus.mem_en or bus.mem_addr) begin
      if (bus.mem_en && mem.exists(bus.mem_addr)) bus.mem_rdata = mem[bus.mem_addr];
      else                                       bus.mem_rdata = 32'h0;
   end

   always @(posedge clk) begin
      if (!reset && bus.mem_en && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
   end

   // Monitor: compares bus activity and ready pulses with the scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.mem_en) begin
            check("access_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
               check("mem_addr", bus.mem_addr, sb_q[0].addr);
               check("mem_we", bus.mem_we, sb_q[0].we);
               if (sb_q[0].we) check("mem_wdata", bus.mem_wdata, sb_q[0].wdata);
               check("grant_owner", bus.grant, sb_q[0].port ? 2'b10 : 2'b01);
            end
         end
         if (bus.cpu_ready || bus.dbg_ready) begin
            exp_t e;
            check("ready_exclusive", 64'(bus.cpu_ready && bus.dbg_ready), 64'd0);
            check("ready_expected", 64'(sb_q.size() != 0), 64'd1);
            check("done_mem_idle", {bus.mem_en, bus.mem_we}, 2'b00);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("ready_port", bus.dbg_ready, e.port);
               if (e.port) check("dbg_rdata", bus.dbg_rdata, e.rdata);
               else        check("cpu_rdata", bus.cpu_rdata, e.rdata);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic push(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata);
      exp_t e;
      e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
      sb_q.push_back(e);
   endtask

   // Ticks until the port's ready is seen; n = ticks taken.
   task automatic wait_ready(input bit port, output int n);
      bit found;
      found = 1'b0;
      n = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         n++;
         if (port ? bus.dbg_ready : bus.cpu_ready) found = 1'b1;
      end
      check(port ? "dbg_ready_seen" : "cpu_ready_seen", 64'(found), 64'd1);
   endtask

   initial begin
      int          n;
      int          bad;
      logic [15:0] cpu_hist;
      logic [15:0] dbg_hist;

      reset         = 1'b1;
      bus.cpu_req   = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dbg_req   = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
      bus.dbg_halt  = 1'b0;
      mem[32'h10] = 32'hDEADBEEF;
      mem[32'h20] = 32'hA5A50020;
      mem[32'h40] = 32'hBAD00040;

      // Reset held 3 cycles
      repeat (3) tick();
      check("rst_grant", bus.grant, 2'b00);
      check("rst_mem", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, '0);
      check("rst_ready", {bus.cpu_ready, bus.dbg_ready}, 2'b00);
      check("rst_rdata", {bus.cpu_rdata, bus.dbg_rdata}, 64'h0);
      reset = 1'b0;
      tick();

      // Core read 0x10, latency and enable width
      push(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
      bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10;
      tick();
      check("t1_grant", bus.grant, 2'b01);
      check("t1_en_c1", bus.mem_en, 1'b1);
      check("t1_addr", bus.mem_addr, 32'h10);
      tick();
      check("t1_en_c2", bus.mem_en, 1'b1);
      check("t1_no_early_ready", bus.cpu_ready, 1'b0);
      tick();
      check("t1_en_off", bus.mem_en, 1'b0);
      check("t1_ready", bus.cpu_ready, 1'b1);
      check("t1_rdata", bus.cpu_rdata, 32'hDEADBEEF);
      bus.cpu_req = 1'b0;
      tick();
      check("t1_ready_pulse", bus.cpu_ready, 1'b0);
      check("t1_grant_idle", bus.grant, 2'b00);
      check("t1_addr_idle", bus.mem_addr, 32'h0);

      // Both requesting from reset: cpu, dbg, cpu, dbg
      do_reset();
      push(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
      push(1'b1, 1'b0, 32'h20, 32'h0, 32'hA5A50020);
      push(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
      push(1'b1, 1'b0, 32'h20, 32'h0, 32'hA5A50020);
      bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10;
      bus.dbg_req = 1'b1; bus.dbg_addr = 32'h20;
      for (int k = 0; k < 16; k++) begin
         tick();
         cpu_hist[k] = bus.cpu_ready;
         dbg_hist[k] = bus.dbg_ready;
         if (k == 14) begin
            bus.cpu_req = 1'b0;
            bus.dbg_req = 1'b0;
         end
      end
      check("rr_cpu_ready_cycles", cpu_hist, 16'h0404);
      check("rr_dbg_ready_cycles", dbg_hist, 16'h4040);
      tick();
      check("rr_idle", bus.grant, 2'b00);

      // Debug write 0x100 then core read of it
      do_reset();
      push(1'b1, 1'b1, 32'h100, 32'h12345678, 32'h0);
      bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 32'h100; bus.dbg_wdata = 32'h12345678;
      wait_ready(1'b1, n);
      bus.dbg_req = 1'b0; bus.dbg_we = 1'b0;
      tick();
      push(1'b0, 1'b0, 32'h100, 32'h0, 32'h12345678);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h100;
      wait_ready(1'b0, n);
      bus.cpu_req = 1'b0;
      tick();
      check("wr_dbg_rdata_kept", bus.dbg_rdata, 32'h0);
      check("wr_cpu_rdata", bus.cpu_rdata, 32'h12345678);

      // dbg_halt blocks the core
      bus.dbg_halt = 1'b1;
      bus.cpu_req  = 1'b1; bus.cpu_addr = 32'h10;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.grant != 2'b00 || bus.cpu_ready || bus.mem_en) bad++;
      end
      check("halt_blocked_cycles", 64'(bad), 64'd0);
      push(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
      bus.dbg_halt = 1'b0;
      tick();
      check("halt_release_grant", bus.grant, 2'b01);
      wait_ready(1'b0, n);
      check("halt_release_latency", 64'(n), 64'd2);
      bus.cpu_req = 1'b0;
      tick();

      // Reset in the middle of a core read
      push(1'b0, 1'b0, 32'h20, 32'h0, 32'hA5A50020);
      bus.cpu_req = 1'b1; bus.cpu_addr = 32'h20;
      tick();
      tick();
      check("abort_pre_en", bus.mem_en, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("abort_async_en", {bus.mem_en, bus.mem_we}, 2'b00);
      check("abort_grant", bus.grant, 2'b00);
      check("abort_rdata_cleared", bus.cpu_rdata, 32'h0);
      tick();
      check("abort_no_ready", bus.cpu_ready, 1'b0);
      reset = 1'b0;
      wait_ready(1'b0, n);
      check("abort_restart_latency", 64'(n), 64'd3);
      bus.cpu_req = 1'b0;
      tick();

      // Address change during ACCESS is ignored
      push(1'b0, 1'b0, 32'h20, 32'h0, 32'hA5A50020);
      bus.cpu_req = 1'b1; bus.cpu_addr = 32'h20;
      tick();
      check("addr_hold_c1", bus.mem_addr, 32'h20);
      bus.cpu_addr = 32'h40;
      tick();
      check("addr_hold_c2", bus.mem_addr, 32'h20);
      tick();
      check("addr_hold_done", bus.mem_addr, 32'h20);
      check("addr_hold_ready", bus.cpu_ready, 1'b1);
      check("addr_hold_rdata", bus.cpu_rdata, 32'hA5A50020);
      bus.cpu_req = 1'b0;
      tick();
      tick();

      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
